mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between the instruction fetch stage (IF) and the data memory stage (DM).
//  Keeps at most one transaction outstanding and latches the owner, address, write enable and write data at grant.
//  Routes the memory response back to the owner and drops fetch responses made stale by a taken branch (if_flush).
//  Sits between the pipeline stages and the memory model, in place of a direct Imem connection.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width
//  STARVE_LIMIT  4   consecutive DM grants with if_req pending before IF wins (only with ARB_STARVE_GUARD_EN)
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, synchronous, active-high
//  if_req      in   1       fetch request; held until if_gnt
//  if_addr     in   ADDR_W  fetch address
//  if_flush    in   1       taken branch; squash the in-flight fetch response
//  if_gnt      out  1       1-cycle pulse: fetch request latched
//  if_rvalid   out  1       fetch data valid
//  if_rdata    out  DATA_W  fetch data
//  dm_req      in   1       data request; held until dm_gnt
//  dm_we       in   1       1 = write, 0 = read
//  dm_addr     in   ADDR_W  data address
//  dm_wdata    in   DATA_W  write data
//  dm_gnt      out  1       1-cycle pulse: data request latched
//  dm_rvalid   out  1       read data valid, or write ack
//  dm_rdata    out  DATA_W  read data
//  mem_req     out  1       request to memory
//  mem_we      out  1       write enable to memory
//  mem_addr    out  ADDR_W  word address; bits [1:0] forced to 0
//  mem_wdata   out  DATA_W  write data to memory
//  mem_ready   in   1       memory accepts mem_req this cycle
//  mem_rvalid  in   1       response valid, for reads and writes
//  mem_rdata   in   DATA_W  response data
// BEHAVIOUR
//  States: IDLE -> ISSUE -> WAIT_RSP -> IDLE.
//  IDLE:
//   - Arbitrate. dm_req beats if_req.
//   - Winner's gnt pulses combinationally.
//   - Latch owner, {addr[ADDR_W-1:2],2'b0}, we (IF: we=0) and wdata; go to ISSUE next cycle.
//   - No request: stay in IDLE, all outputs 0.
//  ISSUE:
//   - mem_req=1; mem_we/mem_addr/mem_wdata come from the latched regs and stay stable.
//   - mem_ready=1 -> WAIT_RSP. mem_ready=0 -> hold ISSUE with the request unchanged.
//  WAIT_RSP:
//   - On mem_rvalid: owner's rvalid=1 for that cycle, rdata=mem_rdata (combinational pass-through); go to IDLE.
//   - Non-owner rvalid stays 0.
//  Minimum latency: gnt@c0, mem_req@c1 (ready@c1), rvalid@c2, next grant@c3.
//  Flush:
//   - if_flush while owner=IF in ISSUE or WAIT_RSP sets a squash flag.
//   - A squashed response is still consumed from memory, but if_rvalid stays 0.
//   - Squash clears on return to IDLE.
//  Simultaneous events:
//   - if_flush in IDLE has no effect on the new arbitration; the same-cycle if_req is the new PC.
//   - if_flush with owner=DM has no effect.
//  mem_rvalid arriving in IDLE or ISSUE is ignored (protocol error); an assertion is flagged in simulation only.
//  rdata outputs are driven to 0 when their rvalid is 0.
//  Reset: state=IDLE, squash=0, starve counter=0.
//   - mem_req, mem_we, mem_addr, mem_wdata = 0.
//   - if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_rdata, dm_rdata = 0.
//  Reset mid-transaction abandons the transaction; any later mem_rvalid is ignored.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//   - A saturating counter increments on each dm_gnt issued while if_req=1.
//   - The counter clears on if_gnt, or on an IDLE cycle with if_req=0.
//   - counter==STARVE_LIMIT: IF wins the next arbitration even if dm_req=1, then the counter clears.
//  ARB_STARVE_GUARD_EN undefined: strict DM priority; counter logic absent.
// STRUCTURE
//  mem_arb_pkg:
//   - arb_state_t enum {IDLE, ISSUE, WAIT_RSP}
//   - arb_owner_t enum {OWN_IF, OWN_DM}
//  One sub-module, mem_arb_pick:
//   - combinational priority select of if_req/dm_req/starve_hit -> arb_owner_t plus a valid bit.
//  The FSM, latches, squash flag and counter stay in mem_port_arbiter.
// TESTING
//  1. if_req=1, addr=0x0000_0006, mem_ready=1, rvalid 1 cycle later with rdata=0xDEAD_BEEF
//     -> if_gnt@c0; mem_addr=0x4, mem_we=0 @c1; if_rvalid=1 and if_rdata=0xDEAD_BEEF @c2.
//  2. if_req and dm_req (we=1, addr=0x40, wdata=0x1234) asserted together
//     -> dm_gnt first, mem_we=1, dm_rvalid on ack; if_gnt at the next IDLE.
//  3. mem_ready=0 for 3 cycles in ISSUE
//     -> mem_req/addr/we/wdata held stable; no new gnt until the response completes.
//  4. if_flush 1 cycle after if_gnt, rvalid 2 cycles later
//     -> if_rvalid stays 0, FSM returns to IDLE, next if_req granted normally.
//  5. rst asserted in WAIT_RSP, then a stray mem_rvalid
//     -> all outputs 0, state IDLE, no rvalid pulse.
//  6. ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, dm_req and if_req held high
//     -> grant pattern DM,DM,DM,DM,IF,DM...; undefined: DM only.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the instruction/data memory port arbiter.
//   arb_state_t : transaction FSM state (IDLE -> ISSUE -> WAIT_RSP -> IDLE)
//   arb_owner_t : which pipeline stage owns the outstanding transaction
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational priority select between the fetch and data-memory requests.
// Data memory normally wins; a starvation hit hands the slot to fetch.
// Ports:
//   i_if_req      in   fetch request pending
//   i_dm_req      in   data request pending
//   i_starve_hit  in   fetch has been starved long enough to take priority
//   o_owner       out  winning requester
//   o_valid       out  at least one request present (o_owner meaningful)
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_dm_req,
    input  logic       i_starve_hit,
    output arb_owner_t o_owner,
    output logic       o_valid
);

    always_comb begin
        o_owner = OWN_DM;
        o_valid = i_if_req | i_dm_req;
        if (i_if_req && i_starve_hit) begin
            o_owner = OWN_IF;
        end else if (i_dm_req) begin
            o_owner = OWN_DM;
        end else if (i_if_req) begin
            o_owner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (IF) and the data
// memory stage (DM). One transaction outstanding at a time; owner, word
// address, write enable and write data are captured at grant. Responses are
// routed back to the owner; a fetch response made stale by if_flush is
// consumed from memory but not delivered.
//
// Optional feature: define ARB_STARVE_GUARD_EN to let fetch win after
// STARVE_LIMIT consecutive DM grants taken while if_req was pending.
// Without it, DM has strict priority.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr/if_flush        fetch request, address, branch squash
//   if_gnt/if_rvalid/if_rdata      fetch grant pulse and response
//   dm_req/dm_we/dm_addr/dm_wdata  data request
//   dm_gnt/dm_rvalid/dm_rdata      data grant pulse and response/write ack
//   mem_req/mem_we/mem_addr/mem_wdata  memory request (mem_addr word aligned)
//   mem_ready                      memory accepts mem_req
//   mem_rvalid/mem_rdata           memory response
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4    // must be >= 1
)
(
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_squash;

    arb_owner_t        w_pick_owner;
    logic              w_pick_vld;
    logic              w_starve_hit;
    logic              w_flush_hit;
    logic              w_grant;
    logic [ADDR_W-1:0] w_addr_sel;
    logic              w_unused_addr_lsb;

    mem_arb_pick u_pick (
        .i_if_req     (if_req),
        .i_dm_req     (dm_req),
        .i_starve_hit (w_starve_hit),
        .o_owner      (w_pick_owner),
        .o_valid      (w_pick_vld)
    );

    assign w_grant    = (r_state == IDLE) && w_pick_vld;
    assign w_addr_sel = (w_pick_owner == OWN_DM) ? dm_addr : if_addr;
    assign w_unused_addr_lsb = ^w_addr_sel[1:0];

    // A flush only matters while a fetch is actually outstanding.
    assign w_flush_hit = if_flush && (r_owner == OWN_IF) && (r_state != IDLE);

    // Next state and all outputs
    always_comb begin
        w_state_nxt = r_state;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        dm_rvalid   = 1'b0;
        dm_rdata    = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    if_gnt      = (w_pick_owner == OWN_IF);
                    dm_gnt      = (w_pick_owner == OWN_DM);
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                if (mem_ready) begin
                    w_state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rvalid) begin
                    w_state_nxt = IDLE;
                    if (r_owner == OWN_DM) begin
                        dm_rvalid = 1'b1;
                        dm_rdata  = mem_rdata;
                    end else if (!(r_squash || w_flush_hit)) begin
                        // A flush arriving with the response also kills it.
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_squash <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE || w_state_nxt == IDLE) begin
                r_squash <= 1'b0;
            end else if (w_flush_hit) begin
                r_squash <= 1'b1;
            end
        end
    end

    // Transaction capture at grant; only observed outside IDLE
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_owner <= w_pick_owner;
            r_addr  <= {w_addr_sel[ADDR_W-1:2], 2'b00};
            r_we    <= (w_pick_owner == OWN_DM) ? dm_we : 1'b0;
            r_wdata <= (w_pick_owner == OWN_DM) ? dm_wdata : '0;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_starve_hit = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts DM wins taken over a waiting fetch; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (if_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_state == IDLE && !if_req) begin
            r_starve_cnt <= '0;
        end else if (dm_gnt && if_req && !w_starve_hit) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    logic w_unused_limit;

    assign w_starve_hit   = 1'b0;
    assign w_unused_limit = (STARVE_LIMIT > 0);
`endif

`ifndef SYNTHESIS
    // Memory must only respond to an accepted request.
    a_rvalid_in_wait: assert property (@(posedge clk) disable iff (rst)
        mem_rvalid |-> (r_state == WAIT_RSP));
`endif

endmodule
